// File: rtl/edge_evt_pkg.sv
// Shared constants for the edge event arbiter: default channel count and
// the encodings of its two-state offer FSM.
package edge_evt_pkg;

    localparam int N_CH_DEF = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/edge_capture.sv
// One monitored channel: registers the level, detects a rising edge, holds
// it as pending until the arbiter takes it, and flags edges that were lost.
module edge_capture (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic take,
    input  logic ovf_clr,
    output logic pending,
    output logic ovf
);

    logic sig_q, sig_d;
    logic pending_q, pending_d;
    logic ovf_q, ovf_d;
    logic rise;

    always_comb begin
        sig_d     = sig;
        rise      = sig & ~sig_q;
        // A rise on the cycle this channel is taken becomes a fresh pending event.
        pending_d = rise | (pending_q & ~take);
        if (rise && pending_q && !take) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q     <= 1'b0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sig_q     <= sig_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector over N_CH channels with round-robin arbitration and a
// valid/ready event port that can sustain one event per cycle.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig,
    input  logic            evt_ready,
    input  logic            ovf_clr,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    output logic [N_CH-1:0] ovf
);

    // Handshake: an event transfers on a rising edge where evt_valid and
    // evt_ready are both high; evt_id is held stable until that edge, and
    // evt_ready is ignored while evt_valid is low.

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] take;
    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            handshake;
    logic            load;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_capture u_cap (
            .clk     (clk),
            .rst     (rst),
            .sig     (sig[i]),
            .take    (take[i]),
            .ovf_clr (ovf_clr),
            .pending (pending[i]),
            .ovf     (ovf[i])
        );
    end

    // First pending channel searching upward from the one after the last grant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % N_CH);
            if (!found && pending[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        take         = '0;
        handshake    = (state_q == ST_OFFER) && evt_ready;
        load         = ((state_q == ST_IDLE) || handshake) && found;
        if (load) begin
            take[win]    = 1'b1;
            evt_id_d     = win;
            last_grant_d = win;
            state_d      = ST_OFFER;
        end else if (handshake) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = (state_q == ST_OFFER);
    assign evt_id    = evt_id_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: a cycle model checked every cycle,
// a queue of hand-computed grant orders, and literal spot checks.
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  sig;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [N-1:0]  ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [IW-1:0] exp_q[$];

    // Model state (higher-level view of the spec rules)
    logic [N-1:0] m_prev, m_pend, m_ovf;
    logic         m_valid;
    int           m_id, m_last;
    bit           m_live = 0;

    edge_event_arbiter #(.N_CH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Model advances on each rising edge from the inputs present before it.
    always @(posedge clk) begin
        logic [N-1:0] rise, tk;
        int w;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_ovf = '0;
            m_valid = 1'b0; m_id = 0; m_last = N - 1;
            m_live = 1;
        end else if (m_live) begin
            rise = sig & ~m_prev;
            tk   = '0;
            w    = rr_pick(m_pend, m_last);
            if ((!m_valid || evt_ready) && w >= 0) begin
                tk[w]   = 1'b1;
                m_valid = 1'b1;
                m_id    = w;
                m_last  = w;
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
            m_ovf  = (rise & m_pend & ~tk) | (ovf_clr ? '0 : m_ovf);
            m_pend = rise | (m_pend & ~tk);
            m_prev = sig;
        end
    end

    // Grant-order scoreboard against hand-computed sequences.
    always @(posedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", int'(evt_id), -1);
            end else begin
                check("grant_order", int'(evt_id), int'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) check("model_id", int'(evt_id), m_id);
            check("model_ovf", int'(ovf), int'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sig = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drain_check(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; sig = '0; evt_ready = 1'b0; ovf_clr = 1'b0;

        // Single event, latency, no repeat while held high
        do_reset();
        check("reset_valid", int'(evt_valid), 0);
        check("reset_ovf", int'(ovf), 0);
        exp_q.push_back(2'd0);
        sig = 4'b0001; evt_ready = 1'b1;
        tick(1); check("s1_lat1_valid", int'(evt_valid), 0);
        tick(1); check("s1_lat2_valid", int'(evt_valid), 1);
        check("s1_id", int'(evt_id), 0);
        tick(1); check("s1_after_valid", int'(evt_valid), 0);
        tick(5); check("s1_no_repeat", int'(evt_valid), 0);
        drain_check("s1_drained");

        // All four rise together: one event per cycle in order 0..3
        do_reset();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        sig = 4'b1111; evt_ready = 1'b1;
        tick(2); check("s2_id0", int'(evt_id), 0);
        tick(1); check("s2_id1", int'(evt_id), 1);
        tick(1); check("s2_id2", int'(evt_id), 2);
        tick(1); check("s2_id3", int'(evt_id), 3);
        tick(1); check("s2_idle", int'(evt_valid), 0);
        drain_check("s2_drained");

        // Stall: offer held stable; second rise on ch1 overflows
        do_reset();
        sig = 4'b0001;
        tick(2);
        for (int c = 0; c < 5; c++) begin
            check("s3_stall_valid", int'(evt_valid), 1);
            check("s3_stall_id", int'(evt_id), 0);
            tick(1);
        end
        sig = 4'b0011; tick(1);
        sig = 4'b0001; tick(1);
        sig = 4'b0011; tick(1);
        check("s3_ovf", int'(ovf), 4'b0010);
        check("s3_still_id", int'(evt_id), 0);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        evt_ready = 1'b1;
        tick(4);
        check("s3_idle", int'(evt_valid), 0);
        check("s3_ovf_sticky", int'(ovf), 4'b0010);
        drain_check("s3_drained");

        // Clear coinciding with a new overflow on ch2
        do_reset();
        sig = 4'b0001; tick(2);
        sig = 4'b0011; tick(1);
        sig = 4'b0001; tick(1);
        sig = 4'b0011; tick(1);
        sig = 4'b0001; tick(1);
        sig = 4'b0101; tick(1);
        sig = 4'b0001; tick(1);
        check("s4_ovf_before", int'(ovf), 4'b0010);
        sig = 4'b0101; ovf_clr = 1'b1; tick(1);
        ovf_clr = 1'b0;
        check("s4_ovf_after", int'(ovf), 4'b0100);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        evt_ready = 1'b1;
        tick(5);
        drain_check("s4_drained");

        // Round robin: last grant 2, ch1 and ch3 pending -> 3 before 1
        do_reset();
        sig = 4'b0100; tick(2);
        check("s5_first", int'(evt_id), 2);
        sig = 4'b1110; tick(2);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
        evt_ready = 1'b1;
        tick(1); check("s5_second", int'(evt_id), 3);
        tick(1); check("s5_third", int'(evt_id), 1);
        tick(2);
        drain_check("s5_drained");

        // Reset mid-offer with three pending and an overflow
        do_reset();
        sig = 4'b1111; tick(2);
        sig = 4'b1101; tick(1);
        sig = 4'b1111; tick(1);
        check("s6_ovf_set", int'(ovf), 4'b0010);
        check("s6_offer", int'(evt_valid), 1);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        check("s6_rst_valid", int'(evt_valid), 0);
        check("s6_rst_ovf", int'(ovf), 0);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        evt_ready = 1'b1;
        tick(1); check("s6_lat1", int'(evt_valid), 0);
        tick(1); check("s6_first_id", int'(evt_id), 0);
        tick(4);
        check("s6_idle", int'(evt_valid), 0);
        drain_check("s6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
